// File: rtl/lsu_pkg.sv
// Shared encodings and op classification helpers for the load/store unit.
// Ops 0-4 are loads and 5-7 are stores; halfword ops need 2-byte alignment, word ops 4-byte.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  function automatic logic is_load(input lsu_op_e op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_sub_word(input lsu_op_e op);
    return (op != OP_LW) && (op != OP_SW);
  endfunction

  function automatic logic is_half(input lsu_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (is_half(op))
      bad = offset[0];
    else if (!is_sub_word(op))
      bad = (offset != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane steering: extracts and extends load data, and merges sub-word store
// data into a word previously read from RAM. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  // Halfword offsets are only ever 0 or 2 here; misaligned requests never reach the RAM.
  always_comb begin
    byte_shift = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
    half_shift = (offset[1] ^ BIG_ENDIAN) ? 5'd16 : 5'd0;
    lane_b     = 8'(word >> byte_shift);
    lane_h     = 16'(word >> half_shift);
  end

  always_comb begin
    load_data = word;
    case (op)
      OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_data = {24'd0, lane_b};
      OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_data = {16'd0, lane_h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    if (op == OP_SB) begin
      lane_mask = 32'h0000_00FF << byte_shift;
      lane_data = {24'd0, wdata[7:0]} << byte_shift;
    end else begin
      lane_mask = 32'h0000_FFFF << half_shift;
      lane_data = {16'd0, wdata} << half_shift;
    end
    store_word = (word & ~lane_mask) | lane_data;
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores as read-modify-write
// against a word-only RAM. Every mem_* and resp_* output is a register.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | req_ready high, waiting for a request
// ST_RD     | mem_read high; load word captured at the closing edge
// ST_WR     | mem_write high with full store word
// ST_RMW_RD | mem_read high; word captured for sub-word merge
// ST_RMW_WR | mem_write high with merged word
// ST_RESP   | resp_valid high for one cycle
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e  state;
  lsu_op_e     op_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] store_word;
  lsu_op_e     req_op_e;

  assign req_op_e = lsu_op_e'(req_op);

  lsu_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .word       (mem_read_data),
    .wdata      (wdata_q),
    .op         (op_q),
    .offset     (off_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      op_q           <= OP_LB;
      off_q          <= 2'b00;
      wdata_q        <= 16'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= 32'd0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op_e;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (is_misaligned(req_op_e, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
              resp_err    <= 1'b0;
              if (is_load(req_op_e)) begin
                state    <= ST_RD;
                mem_read <= 1'b1;
              end else if (!is_sub_word(req_op_e)) begin
                state          <= ST_WR;
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                state    <= ST_RMW_RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          mem_read   <= 1'b0;
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_WR: begin
          mem_write  <= 1'b0;
          resp_rdata <= 32'd0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        // The merged word is registered straight into mem_write_data, which doubles as the merge register.
        ST_RMW_RD: begin
          mem_read       <= 1'b0;
          mem_write      <= 1'b1;
          mem_write_data <= store_word;
          state          <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          mem_write  <= 1'b0;
          resp_rdata <= 32'd0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          resp_err  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Drives a little-endian and a big-endian load_store_unit with identical requests, each on
// its own word RAM, and checks both against a byte-addressed reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic [1:0]  req_ready, resp_valid, resp_err, mem_write, mem_read;
  logic [31:0] resp_rdata [2];
  logic [31:0] mem_address [2];
  logic [31:0] mem_write_data [2];
  logic [31:0] mem_read_data [2] = '{32'd0, 32'd0};

  logic [31:0] ram [2][16];
  logic [7:0]  mb  [2][64];
  logic [31:0] last_rd [2];

  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_data = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  int nrd [2] = '{0, 0};
  int nwr [2] = '{0, 0};
  int overlap = 0;
  int bad_addr = 0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
    .mem_write(mem_write[0]), .mem_read(mem_read[0]), .mem_read_data(mem_read_data[0])
  );

  load_store_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
    .mem_write(mem_write[1]), .mem_read(mem_read[1]), .mem_read_data(mem_read_data[1])
  );

  // Word RAMs: write on rising edge, read data updated on falling edge.
  always @(posedge clock) begin
    for (int e = 0; e < 2; e++) begin
      if (pre_en)
        ram[e][pre_idx] <= pre_data;
      else if (mem_write[e]) begin
        ram[e][mem_address[e][5:2]] <= mem_write_data[e];
        nwr[e] <= nwr[e] + 1;
      end
    end
  end

  always @(negedge clock) begin
    for (int e = 0; e < 2; e++) begin
      if (mem_read[e]) begin
        mem_read_data[e] <= ram[e][mem_address[e][5:2]];
        nrd[e] <= nrd[e] + 1;
      end
      if (mem_read[e] && mem_write[e])
        overlap <= overlap + 1;
      if ((mem_read[e] || mem_write[e]) && (mem_address[e][1:0] != 2'b00 || mem_address[e] > 32'd63))
        bad_addr <= bad_addr + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  // Reference memory is a flat byte array; endianness only decides how bytes form a value.
  function automatic logic [31:0] mem_value(input int e, input int a, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (e == 0) v = v | (32'(mb[e][a + k]) << (8 * k));
      else        v = (v << 8) | 32'(mb[e][a + k]);
    end
    return v;
  endfunction

  task automatic mem_store(input int e, input int a, input int n, input logic [31:0] v);
    for (int k = 0; k < n; k++) begin
      if (e == 0) mb[e][a + k] = v[8 * k +: 8];
      else        mb[e][a + k] = v[8 * (n - 1 - k) +: 8];
    end
  endtask

  function automatic logic [31:0] expect_load(input int e, input logic [2:0] op, input int a);
    logic [31:0] v;
    v = mem_value(e, a, size_of(op));
    case (op)
      OP_LB:   return {{24{v[7]}}, v[7:0]};
      OP_LH:   return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic preload(input int idx, input logic [31:0] w);
    @(negedge clock);
    pre_en = 1'b1; pre_idx = 4'(idx); pre_data = w;
    @(negedge clock);
    pre_en = 1'b0;
    mem_store(0, 4 * idx, 4, w);
    mem_store(1, 4 * idx, 4, w);
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int n, lat, exp_lat, exp_rd, exp_wr;
    int rd0 [2];
    int wr0 [2];
    logic err, store;
    bit seen;
    logic [31:0] exp_data [2];
    n       = size_of(op);
    err     = (addr % n) != 0;
    store   = op >= OP_SB;
    exp_lat = err ? 1 : (op == OP_SB || op == OP_SH) ? 3 : 2;
    exp_rd  = (err || op == OP_SW) ? 0 : 1;
    exp_wr  = (err || !store) ? 0 : 1;
    for (int e = 0; e < 2; e++) begin
      exp_data[e] = (err || store) ? 32'd0 : expect_load(e, op, int'(addr));
      rd0[e] = nrd[e];
      wr0[e] = nwr[e];
    end
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    check("req_ready_idle", req_ready, 2'b11);
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 8) begin
      @(negedge clock); #1;
      lat++;
      if (resp_valid[0]) seen = 1;
    end
    check("resp_timeout", 64'(seen), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_valid_both", resp_valid, 2'b11);
    check("resp_err", resp_err, {err, err});
    for (int e = 0; e < 2; e++) begin
      check(e == 0 ? "rdata_le" : "rdata_be", resp_rdata[e], exp_data[e]);
      check("read_count", 64'(nrd[e] - rd0[e]), 64'(exp_rd));
      check("write_count", 64'(nwr[e] - wr0[e]), 64'(exp_wr));
      last_rd[e] = resp_rdata[e];
      if (store && !err) mem_store(e, int'(addr), n, wd);
    end
    @(negedge clock); #1;
    check("resp_one_cycle", resp_valid, 2'b00);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 2'b11);
    check({tag, "_valid"}, resp_valid, 2'b00);
    check({tag, "_strobes"}, {mem_read, mem_write}, 4'b0000);
    check({tag, "_err"}, resp_err, 2'b00);
    for (int e = 0; e < 2; e++) begin
      check({tag, "_addr"}, mem_address[e], 32'd0);
      check({tag, "_wdata"}, mem_write_data[e], 32'd0);
      check({tag, "_rdata"}, resp_rdata[e], 32'd0);
    end
  endtask

  initial begin
    int pulses, readies, clash;
    int wr_snap [2];
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    preload(2, 32'h8899AABB);
    preload(0, 32'h01020304);
    @(negedge clock); reset_n = 1'b1;

    do_req(OP_LW, 32'h08, 32'd0);
    check("lw_08", last_rd[0], 32'h8899AABB);
    do_req(OP_LB, 32'h09, 32'd0);
    check("lb_09", last_rd[0], 32'hFFFFFFAA);
    do_req(OP_LBU, 32'h09, 32'd0);
    check("lbu_09", last_rd[0], 32'h000000AA);
    do_req(OP_LH, 32'h0A, 32'd0);
    check("lh_0a", last_rd[0], 32'hFFFF8899);
    do_req(OP_SB, 32'h0B, 32'h11);
    check("sb_ram", ram[0][2], 32'h1199AABB);
    check("sb_rdata", last_rd[0], 32'd0);
    do_req(OP_LW, 32'h06, 32'd0);
    do_req(OP_SH, 32'h05, 32'hBEEF);
    do_req(OP_LBU, 32'h00, 32'd0);
    check("be_lbu_00", last_rd[1], 32'h01);
    do_req(OP_LHU, 32'h02, 32'd0);
    check("be_lhu_02", last_rd[1], 32'h0304);

    // Reset while the SH read half of a read-modify-write is in flight.
    wr_snap = nwr;
    @(negedge clock);
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h12; req_wdata = 32'h5A5A;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("rmw_rd_strobe", mem_read, 2'b11);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("reset_strobes", {mem_read, mem_write}, 4'b0000);
    check("reset_no_resp", resp_valid, 2'b00);
    repeat (2) @(posedge clock);
    #1 check_idle_outputs("midreset");
    @(negedge clock); reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock); #1;
      check("post_reset_no_resp", resp_valid, 2'b00);
    end
    for (int e = 0; e < 2; e++) begin
      check("reset_no_write", 64'(nwr[e] - wr_snap[e]), 64'd0);
      check("reset_ram_intact", ram[e][4], mem_value(e, 16, 4));
    end

    // Held request: each load takes accept, RD and RESP cycles, so one accept per three edges.
    pulses = 0; readies = 0; clash = 0;
    @(negedge clock);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h08; req_wdata = 32'd0;
    repeat (12) begin
      @(posedge clock);
      @(negedge clock); #1;
      if (resp_valid[0]) begin
        pulses++;
        check("b2b_rdata_le", resp_rdata[0], expect_load(0, OP_LW, 8));
        check("b2b_rdata_be", resp_rdata[1], expect_load(1, OP_LW, 8));
      end
      if (req_ready[0]) readies++;
      if (req_ready[0] && resp_valid[0]) clash++;
    end
    req_valid = 1'b0;
    check("b2b_pulses", 64'(pulses), 64'd4);
    check("b2b_accept_windows", 64'(readies), 64'd4);
    check("b2b_ready_during_resp", 64'(clash), 64'd0);

    for (int t = 0; t < 60; t++) begin
      do_req(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    for (int e = 0; e < 2; e++)
      for (int i = 0; i < 16; i++)
        check("final_ram", ram[e][i], mem_value(e, 4 * i, 4));
    check("rd_wr_overlap", 64'(overlap), 64'd0);
    check("word_address", 64'(bad_addr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
